// File: rtl/controller_pkg.sv
// Shared types and constants for the NES-style controller scanner.
package controller_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LATCH   = 3'd1,
      CLK_LO  = 3'd2,
      CLK_HI  = 3'd3,
      COMMIT  = 3'd4
   } state_e;

   localparam int unsigned BTN_A      = 7;
   localparam int unsigned BTN_B      = 6;
   localparam int unsigned BTN_SELECT = 5;
   localparam int unsigned BTN_START  = 4;
   localparam int unsigned BTN_UP     = 3;
   localparam int unsigned BTN_DOWN   = 2;
   localparam int unsigned BTN_LEFT   = 1;
   localparam int unsigned BTN_RIGHT  = 0;

   // LATCH takes two phases, each of the seven clock pulses takes two more.
   localparam int unsigned CTRL_PHASES = 16;

endpackage

// File: rtl/controller_scanner_bit_synchronizer.sv
// Two-flop synchronizer; resets to 1 so an idle (released) line reads as not pressed.
module bit_synchronizer (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;

   // Two-stage capture of the asynchronous pin
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b1;
         q_o    <= 1'b1;
      end else begin
         meta_q <= d_i;
         q_o    <= meta_q;
      end
   end

endmodule

// File: rtl/controller_scanner.sv
// Scans two serial game controllers on vblank or CPU write and presents
// atomically committed button bytes on the CPU read path.
module controller_scanner
   import controller_pkg::*;
#(
   parameter int unsigned CLK_DIV = 75
) (
   input  logic       clk_12_5875,
   input  logic       rst,
   input  logic       vblank_start,
   input  logic       SELECT_controller,
   input  logic       address_lsb,
   input  logic       write_enable,
   input  logic       ctrl_data0,
   input  logic       ctrl_data1,
   output logic       ctrl_latch,
   output logic       ctrl_clk,
   output logic [7:0] data_out,
   output logic       data_out_enable,
   output logic       busy
);

   localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
   localparam logic [DIV_W-1:0] PHASE_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       sh0_q, sh0_d, sh1_q, sh1_d;
   logic [7:0]       ctrl0_q, ctrl0_d, ctrl1_q, ctrl1_d;
   logic             latch_q, clk_q, busy_q;
   logic             sync0_s, sync1_s, start_s, phase_end_s;

   bit_synchronizer u_sync0 (.clk_i(clk_12_5875), .rst_i(rst), .d_i(ctrl_data0), .q_o(sync0_s));
   bit_synchronizer u_sync1 (.clk_i(clk_12_5875), .rst_i(rst), .d_i(ctrl_data1), .q_o(sync1_s));

   assign start_s = vblank_start | (SELECT_controller & write_enable);

   // Next-state, divider, bit index and sampling logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sh0_d   = sh0_q;
      sh1_d   = sh1_q;
      ctrl0_d = ctrl0_q;
      ctrl1_d = ctrl1_q;
      if (state_q == LATCH) begin
         phase_end_s = (div_q == LATCH_LAST);
      end else begin
         phase_end_s = (div_q == PHASE_LAST);
      end
      case (state_q)
         IDLE: begin
            idx_d = 3'd7;
            if (start_s) begin
               state_d = LATCH;
            end else begin
               state_d = IDLE;
            end
         end
         LATCH: begin
            if (phase_end_s) begin
               sh0_d   = {sh0_q[6:0], ~sync0_s};
               sh1_d   = {sh1_q[6:0], ~sync1_s};
               idx_d   = idx_q - 3'd1;
               state_d = CLK_LO;
            end else begin
               state_d = LATCH;
            end
         end
         CLK_LO: begin
            if (phase_end_s) begin
               state_d = CLK_HI;
            end else begin
               state_d = CLK_LO;
            end
         end
         CLK_HI: begin
            if (phase_end_s) begin
               sh0_d = {sh0_q[6:0], ~sync0_s};
               sh1_d = {sh1_q[6:0], ~sync1_s};
               if (idx_q == 3'd0) begin
                  state_d = COMMIT;
               end else begin
                  idx_d   = idx_q - 3'd1;
                  state_d = CLK_LO;
               end
            end else begin
               state_d = CLK_HI;
            end
         end
         COMMIT: begin
            ctrl0_d = sh0_q;
            ctrl1_d = sh1_q;
            idx_d   = 3'd7;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Every state entry restarts the phase count; IDLE holds it at zero.
      if ((state_d != state_q) || (state_q == IDLE)) begin
         div_d = '0;
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   // State, datapath and registered line drivers
   always_ff @(posedge clk_12_5875 or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         idx_q   <= 3'd7;
         sh0_q   <= 8'h00;
         sh1_q   <= 8'h00;
         ctrl0_q <= 8'h00;
         ctrl1_q <= 8'h00;
         latch_q <= 1'b0;
         clk_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         idx_q   <= idx_d;
         sh0_q   <= sh0_d;
         sh1_q   <= sh1_d;
         ctrl0_q <= ctrl0_d;
         ctrl1_q <= ctrl1_d;
         latch_q <= (state_d == LATCH);
         clk_q   <= (state_d != CLK_LO);
         busy_q  <= (state_d != IDLE);
      end
   end

   assign ctrl_latch = latch_q;
   assign ctrl_clk   = clk_q;
   assign busy       = busy_q;

   // CPU read mux from the committed registers
   always_comb begin
      data_out_enable = SELECT_controller & ~write_enable;
      if (data_out_enable) begin
         data_out = address_lsb ? ctrl1_q : ctrl0_q;
      end else begin
         data_out = 8'h00;
      end
   end

endmodule
